multiport_instr_mem: RTL and testbench
======================================

Name: multiport_instr_mem

Overview:
- Shared instruction store for the multi-core matrix-multiply array.
- Generalises the fixed 4-address, 256x8 program ROM:
  - parametrised data width, depth and core count.
  - one independent registered read port per core, each with its own data and valid.
  - runtime program loader (valid/ready stream) replaces hard-coded initial contents.
- Sits between the host/loader path and each core's fetch stage.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
NUM_PORTS, 4, number of core read ports
END_OPCODE, 8'd38, word returned for guarded out-of-range reads (optional feature only)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin (or restart) program load at address 0
load_valid  in  1  load_data is valid this cycle
load_data  in  DATA_W  instruction word to store
load_last  in  1  qualifies the final word of the program
load_ready  out  1  loader accepts a word this cycle
load_busy  out  1  load in progress
load_done  out  1  one-cycle pulse when a load completes
load_count  out  ADDR_W+1  number of words stored by the last or current load
rd_en  in  NUM_PORTS  per-port fetch request
rd_addr  in  NUM_PORTS*ADDR_W  flattened per-port fetch address; port p at [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_PORTS*DATA_W  flattened per-port instruction
rd_valid  out  NUM_PORTS  per-port rd_data valid
rd_oob  out  NUM_PORTS  per-port out-of-range flag (tied 0 without the optional feature)

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = IDLE, write pointer = 0, load_count = 0. Memory array is not cleared; contents survive reset.
- FSM states:
  - IDLE: no program loaded.
  - LOAD: accepting words.
  - RUN: program loaded, read ports serve fetches.
- Transitions:
  - IDLE/RUN --load_start--> LOAD; pointer and load_count cleared.
  - LOAD --accepted word with load_last--> RUN.
  - LOAD --accepted word at address DEPTH-1--> RUN. Storage full; no wrap.
  - LOAD --load_start--> LOAD. Restart: pointer and count back to 0, earlier words of the aborted load stay in the array.
- load_ready = (state == LOAD), combinational from state.
  - The cycle that sees load_start never accepts data.
- Word accepted when load_valid & load_ready:
  - mem[ptr] <= load_data; ptr++; load_count++.
- load_done pulses 1 in the cycle after the final word is accepted.
- load_busy = (state == LOAD).
- load_start in the same cycle as a load_last acceptance: restart wins, no load_done.
- Read ports (each independent):
  - rd_en[p] high in RUN: next cycle rd_data[p] = mem[rd_addr[p]] and rd_valid[p] = 1. Latency is 1 cycle.
  - rd_en[p] low: rd_valid[p] = 0 next cycle; rd_data[p] holds its last value.
  - In IDLE or LOAD, rd_en is ignored: rd_valid = 0, rd_data held.
- Same address on several ports in one cycle: all ports return the same word. No arbitration and no stall.
- Read during a write is impossible by construction, because reads are disabled in LOAD.
- Reset mid-load: returns to IDLE, load_count = 0, and cores must not fetch until a new load completes.

Optional Feature:
- Macro: MULTIPORT_IMEM_ADDR_GUARD_EN.
- Defined:
  - A RUN read with rd_addr[p] >= load_count returns END_OPCODE, with rd_valid[p] = 1 and rd_oob[p] = 1 for that cycle.
  - A stray core therefore halts on END instead of executing stale words.
- Undefined:
  - Raw mem[rd_addr[p]] is returned; rd_oob is constant 0.
  - No comparator logic is generated.

Test Plan:
- Reset, then load_start; stream 0x08, 0x09, 0x0B with load_last on 0x0B -> load_ready high from the cycle after start, load_done pulse one cycle after the third word, load_count = 3, state RUN.
- RUN; rd_en = 4'b1111 with addresses 0, 1, 2, 1 -> next cycle rd_data = {0x09, 0x0B, 0x09, 0x08} (port 3..0), rd_valid = 4'b1111. Deassert rd_en -> rd_valid = 0, data held.
- Mid-load, after 2 words, assert load_start, then load 0xAA with load_last -> load_count = 1, mem[0] = 0xAA, mem[1] keeps the earlier word.
- Load 256 words without load_last -> automatic RUN after the word at address 255, load_ready drops, load_count = 256, a 257th load_valid is ignored.
- Assert reset_n low during LOAD, then release -> all outputs 0, IDLE; rd_en = 4'b1111 gives rd_valid = 0.
- With MULTIPORT_IMEM_ADDR_GUARD_EN, load 3 words, read address 5 on port 2 -> rd_data[2] = 0x26, rd_oob = 4'b0100. Without the macro -> raw mem[5], rd_oob = 0.

Source files
------------

// File: rtl/multiport_instr_mem.sv
// Shared instruction store: streamed program loader plus one registered read port per core.
// Optional out-of-range read guard is enabled with `define MULTIPORT_IMEM_ADDR_GUARD_EN.
module multiport_instr_mem #(
  parameter int DATA_W    = 32'd8,
  parameter int ADDR_W    = 32'd8,
  parameter int NUM_PORTS = 32'd4
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
  ,
  parameter logic [DATA_W-1:0] END_OPCODE = 8'd38
`endif
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  output logic                          load_busy,
  output logic                          load_done,
  output logic [ADDR_W:0]               load_count,
  input  logic [NUM_PORTS-1:0]          rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
  output logic [NUM_PORTS-1:0]          rd_valid,
  output logic [NUM_PORTS-1:0]          rd_oob
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W:0]     count_r;
  logic                done_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                accept_s;
  logic                run_s;

  // A restart cycle never stores data, even though ready is up in LOAD.
  assign accept_s   = load_valid && (state_r == ST_LOAD) && !load_start;
  assign run_s      = (state_r == ST_RUN);
  assign load_ready = (state_r == ST_LOAD);
  assign load_busy  = (state_r == ST_LOAD);
  assign load_done  = done_r;
  assign load_count = count_r;

  // Loader FSM: pointer, word count and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {ADDR_W{1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load_start) begin
        state_r <= ST_LOAD;
        ptr_r   <= {ADDR_W{1'b0}};
        count_r <= {(ADDR_W+1){1'b0}};
      end else begin
        case (state_r)
          ST_LOAD: begin
            if (accept_s) begin
              ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
              // Storage full ends the load just like load_last; the pointer never wraps into use.
              if (load_last || (ptr_r == {ADDR_W{1'b1}})) begin
                state_r <= ST_RUN;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_LOAD;
              end
            end else begin
              state_r <= ST_LOAD;
            end
          end
          ST_RUN:  state_r <= ST_RUN;
          ST_IDLE: state_r <= ST_IDLE;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // Program storage write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem_r[ptr_r] <= load_data;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
    logic              oob_r;
`endif

    assign addr_s                        = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*DATA_W +: DATA_W]   = data_r;
    assign rd_valid[p]                   = valid_r;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
    assign rd_oob[p]                     = oob_r;
`endif

    // Per-core registered fetch; data holds whenever no fetch is served.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_r  <= {DATA_W{1'b0}};
        valid_r <= 1'b0;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
        oob_r   <= 1'b0;
`endif
      end else if (rd_en[p] && run_s) begin
        valid_r <= 1'b1;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
        if ({1'b0, addr_s} >= count_r) begin
          data_r <= END_OPCODE;
          oob_r  <= 1'b1;
        end else begin
          data_r <= mem_r[addr_s];
          oob_r  <= 1'b0;
        end
`else
        data_r  <= mem_r[addr_s];
`endif
      end else begin
        valid_r <= 1'b0;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
        oob_r   <= 1'b0;
`endif
      end
    end
  end

`ifndef MULTIPORT_IMEM_ADDR_GUARD_EN
  assign rd_oob = {NUM_PORTS{1'b0}};
`endif

endmodule

// File: tb/tb_multiport_instr_mem.sv
// Scoreboard bench for multiport_instr_mem: load sequences, multi-port reads, restart, full load, reset.
module tb_multiport_instr_mem;

  logic        clock;
  logic        reset_n;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
  logic [8:0]  load_count;
  logic [3:0]  rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  rd_oob;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       oob;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_mem [256];
  int         model_ptr;
  int         model_count;
  logic [7:0] exp_hold [4];
  int         errors;
  int         checks;

  multiport_instr_mem dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_oob     (rd_oob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clock);
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start  = 1'b0;
    model_ptr   = 0;
    model_count = 0;
    check_val("busy_after_start", {31'd0, load_busy}, 32'd1);
  endtask

  task automatic push_word(input logic [7:0] d, input logic last);
    @(negedge clock);
    check_val("ready_before_word", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    model_mem[model_ptr] = d;
    model_ptr   = (model_ptr + 1) % 256;
    model_count = model_count + 1;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  function automatic exp_t model_read(input int p, input logic [7:0] a);
    exp_t e;
    e.port = p;
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
    if (int'(a) >= model_count) begin
      e.data = 8'd38;
      e.oob  = 1'b1;
    end else begin
      e.data = model_mem[a];
      e.oob  = 1'b0;
    end
`else
    e.data = model_mem[a];
    e.oob  = 1'b0;
`endif
    return e;
  endfunction

  task automatic read_cycle(input logic [3:0] en, input logic [31:0] addrs, input bit running);
    exp_t e;
    logic [3:0] exp_valid;
    exp_valid = running ? en : 4'b0000;
    @(negedge clock);
    rd_en   = en;
    rd_addr = addrs;
    for (int p = 0; p < 4; p++) begin
      if (exp_valid[p]) begin
        e = model_read(p, addrs[p*8 +: 8]);
        sb_q.push_back(e);
        exp_hold[p] = e.data;
      end
    end
    @(posedge clock);
    #1;
    rd_en = 4'b0000;
    check_val("rd_valid", {28'd0, rd_valid}, {28'd0, exp_valid});
    for (int p = 0; p < 4; p++) begin
      if (rd_valid[p]) begin
        if (sb_q.size() == 0) begin
          check_val("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("sb_port", p, e.port);
          check_val("rd_data", {24'd0, rd_data[p*8 +: 8]}, {24'd0, e.data});
          check_val("rd_oob", {31'd0, rd_oob[p]}, {31'd0, e.oob});
        end
      end else begin
        check_val("rd_data_hold", {24'd0, rd_data[p*8 +: 8]}, {24'd0, exp_hold[p]});
        check_val("rd_oob_idle", {31'd0, rd_oob[p]}, 32'd0);
      end
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    model_ptr   = 0;
    model_count = 0;
    for (int p = 0; p < 4; p++) exp_hold[p] = 8'h00;
    reset_n    = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    rd_en      = 4'b0000;
    rd_addr    = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_ready", {31'd0, load_ready}, 32'd0);
    check_val("rst_count", {23'd0, load_count}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reads in IDLE are ignored
    read_cycle(4'b1111, 32'h0302_0100, 1'b0);

    // Basic three-word load
    start_load();
    push_word(8'h08, 1'b0);
    push_word(8'h09, 1'b0);
    push_word(8'h0B, 1'b1);
    check_val("done_pulse", {31'd0, load_done}, 32'd1);
    check_val("count_3", {23'd0, load_count}, 32'd3);
    check_val("busy_run", {31'd0, load_busy}, 32'd0);
    @(posedge clock);
    #1;
    check_val("done_cleared", {31'd0, load_done}, 32'd0);

    // Four ports, shared address on ports 1 and 3, then hold
    read_cycle(4'b1111, 32'h0102_0100, 1'b1);
    read_cycle(4'b0000, 32'h0000_0000, 1'b1);
    read_cycle(4'b0101, 32'h0000_0200, 1'b1);

    // Restart mid-load
    start_load();
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b0);
    start_load();
    push_word(8'hAA, 1'b1);
    check_val("restart_done", {31'd0, load_done}, 32'd1);
    check_val("restart_count", {23'd0, load_count}, 32'd1);
    read_cycle(4'b0011, 32'h0000_0100, 1'b1);

    // Full 256-word load ends without load_last
    start_load();
    for (int i = 0; i < 256; i++) begin
      push_word(8'(i) ^ 8'h5A, 1'b0);
    end
    check_val("full_done", {31'd0, load_done}, 32'd1);
    check_val("full_count", {23'd0, load_count}, 32'd256);
    check_val("full_ready_low", {31'd0, load_ready}, 32'd0);
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    check_val("extra_count", {23'd0, load_count}, 32'd256);
    check_val("extra_busy", {31'd0, load_busy}, 32'd0);
    read_cycle(4'b1111, 32'h0580_FF00, 1'b1);

    // Reset during a load
    start_load();
    push_word(8'h08, 1'b0);
    push_word(8'h09, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_count = 0;
    for (int p = 0; p < 4; p++) exp_hold[p] = 8'h00;
    check_val("midrst_busy", {31'd0, load_busy}, 32'd0);
    check_val("midrst_count", {23'd0, load_count}, 32'd0);
    check_val("midrst_rd_data", rd_data, 32'd0);
    check_val("midrst_valid", {28'd0, rd_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    read_cycle(4'b1111, 32'h0302_0100, 1'b0);

    // Out-of-range read on port 2
    start_load();
    push_word(8'h08, 1'b0);
    push_word(8'h09, 1'b0);
    push_word(8'h0B, 1'b1);
    read_cycle(4'b0100, 32'h0005_0000, 1'b1);
`ifdef MULTIPORT_IMEM_ADDR_GUARD_EN
    check_val("guard_oob_vec", {28'd0, rd_oob}, 32'h4);
    check_val("guard_data", {24'd0, rd_data[23:16]}, 32'h26);
`else
    check_val("raw_oob_vec", {28'd0, rd_oob}, 32'h0);
    check_val("raw_data", {24'd0, rd_data[23:16]}, 32'h5F);
`endif

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
